// File: rtl/fft_pkg.sv
// Shared constants, state encoding and index helpers for the FFT address controller.
package fft_pkg;

    localparam int FFT_N   = 9;
    localparam int FFT_LEN = 1 << FFT_N;
    localparam int S_W     = $clog2(FFT_N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [FFT_N-1:0] bitrev(input logic [FFT_N-1:0] x);
        logic [FFT_N-1:0] r;
        for (int i = 0; i < FFT_N; i++) begin
            r[i] = x[FFT_N-1-i];
        end
        return r;
    endfunction

    // Rotate left inside FFT_N bits; sh ranges over 0..FFT_N-1.
    function automatic logic [FFT_N-1:0] rotl(input logic [FFT_N-1:0] x,
                                              input logic [S_W-1:0]   sh);
        return (x << sh) | (x >> (S_W'(FFT_N) - sh));
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register carrying {valid, idx_a, idx_b} from read issue to write-back.
module fft_addr_delay #(
    parameter int N      = 9,
    parameter int BF_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    output logic [N-1:0] out_a,
    output logic [N-1:0] out_b
);

    logic [2*N:0] pipe [BF_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BF_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {in_valid, in_a, in_b};
            for (int i = 1; i < BF_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign {out_valid, out_a, out_b} = pipe[BF_LAT-1];

endmodule

// File: rtl/fft_addr_ctrl.sv
// Address/control sequencer for an in-place radix-2 DIT FFT using ping-pong banks.
// N must equal fft_pkg::FFT_N since the index helpers are sized by the package.
import fft_pkg::*;

module fft_addr_ctrl #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = FFT_N,
    parameter int BF_LAT    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fft_start,
    input  logic         fft_load,
    input  logic [N-1:0] add_rd,
    output logic [N-1:0] r0_add_a,
    output logic [N-1:0] r0_add_b,
    output logic [N-1:0] r1_add_a,
    output logic [N-1:0] r1_add_b,
    output logic [N-2:0] add_tw,
    output logic         mem_write0,
    output logic         mem_write1,
    output logic         read_sel,
    output logic         fft_done
);

    localparam int            D_W         = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [N-2:0]  B_MAX       = N'(FFT_LEN / 2 - 1);
    localparam logic [N-2:0]  TW_ONES     = '1;
    localparam logic          RESULT_BANK = 1'(N % 2);

    state_t         state, state_nxt;
    logic [N-2:0]   bfly;
    logic [S_W-1:0] stage;
    logic           drain;
    logic [D_W-1:0] drain_cnt;

    logic           issue, drain_tc, last_stage;
    logic [N-1:0]   idx_a, idx_b, d_a, d_b;
    logic           d_valid;
    logic [N-2:0]   tw_mask;

    assign issue      = (state == RUN) && !drain;
    assign drain_tc   = drain && (drain_cnt == '0);
    assign last_stage = (stage == S_W'(N-1));
    assign idx_a      = rotl({bfly, 1'b0}, stage);
    assign idx_b      = rotl({bfly, 1'b1}, stage);
    assign tw_mask    = TW_ONES << (S_W'(N-1) - stage);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bfly      <= '0;
            stage     <= '0;
            drain     <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state != RUN) begin
                bfly      <= '0;
                stage     <= '0;
                drain     <= 1'b0;
                drain_cnt <= '0;
            end else if (!drain) begin
                bfly <= bfly + 1'b1;
                if (bfly == B_MAX) begin
                    drain     <= 1'b1;
                    drain_cnt <= D_W'(BF_LAT - 1);
                end
            end else if (drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end else begin
                // delay line is empty now; bfly already wrapped to 0
                drain <= 1'b0;
                stage <= last_stage ? '0 : stage + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        r0_add_a   = '0;
        r0_add_b   = '0;
        r1_add_a   = '0;
        r1_add_b   = '0;
        add_tw     = '0;
        mem_write0 = 1'b0;
        mem_write1 = 1'b0;
        read_sel   = 1'b0;

        case (state)
            IDLE:    if (fft_start) state_nxt = RUN;
            RUN:     if (drain_tc && last_stage) state_nxt = DONE;
            DONE: begin
                if (fft_start)     state_nxt = RUN;
                else if (fft_load) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state == RUN) begin
            read_sel = stage[0];
            add_tw   = tw_mask & bfly;
            if (!stage[0]) begin
                r0_add_a   = idx_a;
                r0_add_b   = idx_b;
                r1_add_a   = d_a;
                r1_add_b   = d_b;
                mem_write1 = d_valid;
            end else begin
                r1_add_a   = idx_a;
                r1_add_b   = idx_b;
                r0_add_a   = d_a;
                r0_add_b   = d_b;
                mem_write0 = d_valid;
            end
        end else begin
            r0_add_a   = bitrev(add_rd);
            r0_add_b   = bitrev(add_rd);
            r1_add_a   = add_rd;
            r1_add_b   = add_rd;
            mem_write0 = fft_load;
            read_sel   = (state == DONE) ? RESULT_BANK : 1'b0;
        end
    end

    assign fft_done = (state == DONE);

    fft_addr_delay #(
        .N      (N),
        .BF_LAT (BF_LAT)
    ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue),
        .in_a      (idx_a),
        .in_b      (idx_b),
        .out_valid (d_valid),
        .out_a     (d_a),
        .out_b     (d_b)
    );

endmodule

// File: tb/tb_fft_addr_ctrl.sv
// Randomized self-checking bench for fft_addr_ctrl against an arithmetic address model.
module tb_fft_addr_ctrl;

    localparam int NB        = 9;
    localparam int HALF      = 256;
    localparam int LAT       = 2;
    localparam int STAGE_CYC = HALF + LAT;
    localparam int RUN_CYC   = NB * STAGE_CYC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fft_start = 1'b0;
    logic        fft_load = 1'b0;
    logic [8:0]  add_rd = '0;
    logic [8:0]  r0_add_a, r0_add_b, r1_add_a, r1_add_b;
    logic [7:0]  add_tw;
    logic        mem_write0, mem_write1, read_sel, fft_done;
    logic [47:0] obs_vec;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_addr_ctrl #(.BIT_WIDTH(16), .N(NB), .BF_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .fft_start  (fft_start),
        .fft_load   (fft_load),
        .add_rd     (add_rd),
        .r0_add_a   (r0_add_a),
        .r0_add_b   (r0_add_b),
        .r1_add_a   (r1_add_a),
        .r1_add_b   (r1_add_b),
        .add_tw     (add_tw),
        .mem_write0 (mem_write0),
        .mem_write1 (mem_write1),
        .read_sel   (read_sel),
        .fft_done   (fft_done)
    );

    assign obs_vec = {r0_add_a, r0_add_b, r1_add_a, r1_add_b, add_tw,
                      mem_write0, mem_write1, read_sel, fft_done};

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bitrev9(input int x);
        int r = 0;
        for (int i = 0; i < NB; i++) r = r * 2 + ((x >> i) % 2);
        return r;
    endfunction

    function automatic int rot9(input int x, input int s);
        return ((x << s) % 512) + (x >> (NB - s));
    endfunction

    // Expected outputs for RUN cycle t, plus a mask of the fields that are defined.
    task automatic model_cycle(input int t, output logic [47:0] e, output logic [47:0] care);
        int s, k, b, rda, rdb, wa, wb, tw, step;
        bit wv;
        s    = t / STAGE_CYC;
        k    = t % STAGE_CYC;
        b    = (k < HALF) ? k : 0;
        rda  = rot9(2 * b, s);
        rdb  = rot9(2 * b + 1, s);
        step = 1 << (NB - 1 - s);
        tw   = (b / step) * step;
        wv   = (k >= LAT);
        wa   = wv ? rot9(2 * (k - LAT), s) : 0;
        wb   = wv ? rot9(2 * (k - LAT) + 1, s) : 0;
        if (s % 2 == 0) begin
            e    = {9'(rda), 9'(rdb), 9'(wa), 9'(wb), 8'(tw), 1'b0, wv, 1'b0, 1'b0};
            care = {18'h3ffff, wv ? 18'h3ffff : 18'h0, 12'hfff};
        end else begin
            e    = {9'(wa), 9'(wb), 9'(rda), 9'(rdb), 8'(tw), wv, 1'b0, 1'b1, 1'b0};
            care = {wv ? 18'h3ffff : 18'h0, 18'h3ffff, 12'hfff};
        end
    endtask

    task automatic run_fft(input bit disturb, output int cycles);
        logic [47:0] e, care;
        int hit_t, load_t;
        hit_t  = disturb ? int'($urandom_range(10, 2000)) : -1;
        load_t = disturb ? int'($urandom_range(10, 2000)) : -1;
        @(posedge clk); #1;
        fft_load  = 1'b0;
        fft_start = 1'b1;
        @(posedge clk); #1;
        fft_start = 1'b0;
        cycles = 0;
        while (1) begin
            @(negedge clk);
            if (fft_done) break;
            if (cycles >= RUN_CYC + 50) begin
                check("run_timeout", 48'(cycles), 48'(RUN_CYC));
                break;
            end
            model_cycle(cycles, e, care);
            check("run", obs_vec & care, e & care);
            add_rd    = 9'($urandom);
            fft_start = (cycles == hit_t);
            fft_load  = (cycles == load_t);
            cycles++;
        end
        fft_start = 1'b0;
        fft_load  = 1'b0;
    endtask

    initial begin
        int ld_in  [4] = '{1, 3, 511, 0};
        int ld_exp [4] = '{256, 384, 511, 0};
        int cyc, v, n;

        #23;
        check("rst_mw0",  48'(mem_write0), 48'd0);
        check("rst_mw1",  48'(mem_write1), 48'd0);
        check("rst_rsel", 48'(read_sel),   48'd0);
        check("rst_done", 48'(fft_done),   48'd0);
        check("rst_tw",   48'(add_tw),     48'd0);

        @(negedge clk);
        reset    = 1'b1;
        fft_load = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = (i < 4) ? ld_in[i] : int'($urandom_range(0, 511));
            @(negedge clk);
            add_rd = 9'(v);
            #1;
            check("ld_r0a", 48'(r0_add_a), 48'((i < 4) ? ld_exp[i] : bitrev9(v)));
            check("ld_r0b", 48'(r0_add_b), 48'(bitrev9(v)));
            check("ld_r1a", 48'(r1_add_a), 48'(v));
            check("ld_r1b", 48'(r1_add_b), 48'(v));
            check("ld_mw",  48'({mem_write0, mem_write1}), 48'b10);
        end

        run_fft(1'b1, cyc);
        check("run1_cycles", 48'(cyc), 48'(RUN_CYC));

        for (int i = 0; i < 4; i++) begin
            v = int'($urandom_range(0, 511));
            @(negedge clk);
            add_rd = 9'(v);
            #1;
            check("done_flags", 48'({read_sel, mem_write0, mem_write1, fft_done}), 48'b1001);
            check("done_r1a",   48'(r1_add_a), 48'(v));
            check("done_r0a",   48'(r0_add_a), 48'(bitrev9(v)));
            check("done_tw",    48'(add_tw),   48'd0);
        end

        @(negedge clk);
        fft_load = 1'b1;
        @(negedge clk);
        check("idle_flags", 48'({read_sel, mem_write0, fft_done}), 48'b010);
        fft_load = 1'b0;

        run_fft(1'b0, cyc);
        check("run2_cycles", 48'(cyc), 48'(RUN_CYC));

        @(negedge clk);
        fft_start = 1'b1;
        fft_load  = 1'b1;
        @(negedge clk);
        check("prio_flags", 48'({fft_done, mem_write0, read_sel}), 48'b000);
        fft_start = 1'b0;
        fft_load  = 1'b0;

        n = int'($urandom_range(300, 1500));
        repeat (n) @(negedge clk);
        v = int'($urandom_range(0, 511));
        add_rd = 9'(v);
        #2;
        reset = 1'b0;
        #1;
        check("arst_flags", 48'({mem_write0, mem_write1, read_sel, fft_done}), 48'b0000);
        check("arst_tw",    48'(add_tw),   48'd0);
        check("arst_r1a",   48'(r1_add_a), 48'(v));
        check("arst_r0a",   48'(r0_add_a), 48'(bitrev9(v)));
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst", 48'({mem_write1, read_sel, fft_done}), 48'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
